// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared types and excitation codes for the JK excitation driver
// Build option JK_TOGGLE_EN selects the toggle excitation form in jk_excite_cell.
package jk_pkg;

  // Controller phases: idle, one-cycle J/K pulse, one-cycle readback compare
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    VERIFY = 2'd2
  } jkState_t;

  // Excitation codes, packed as {J, K}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Width of the retry counter; a zero-retry build still gets a 1-bit port
  function automatic int retryWidth(input int maxRetry);
    return (maxRetry < 1) ? 1 : $clog2(maxRetry + 1);
  endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// rtl/jk_excite_cell.sv - per-bit (q,t) to {J,K} excitation mapping
// Build option JK_TOGGLE_EN: differing bits are driven with J=K=1 instead of set/reset.
module jk_excite_cell
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  logic [1:0] jkCode;

  // Choose the excitation that carries the flop from q to t in one clock
  always_comb begin
    jkCode = JK_HOLD;
`ifdef JK_TOGGLE_EN
    if (q != t) begin
      jkCode = JK_TOGGLE;
    end
`else
    case ({q, t})
      2'b01:   jkCode = JK_SET;
      2'b10:   jkCode = JK_RESET;
      default: jkCode = JK_HOLD;
    endcase
`endif
  end

  assign j = jkCode[1];
  assign k = jkCode[0];

endmodule

// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - drives an external JK flop bank to a target word with verify and retry
// Build option JK_TOGGLE_EN: toggle excitation form (handled inside jk_excite_cell).
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                                 Clock,
  input  logic                                 ClrN,
  input  logic                                 start,
  input  logic [WIDTH-1:0]                     target,
  input  logic [WIDTH-1:0]                     q_fb,
  output logic [WIDTH-1:0]                     J,
  output logic [WIDTH-1:0]                     K,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [retryWidth(MAX_RETRY)-1:0]     retries
);

  localparam int RW = retryWidth(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  jkState_t         state;
  logic [WIDTH-1:0] targetR;
  logic [WIDTH-1:0] exciteT;
  logic [WIDTH-1:0] jNext;
  logic [WIDTH-1:0] kNext;

  // A fresh request excites toward the live target; a retry toward the latched one
  assign exciteT = (state == IDLE) ? target : targetR;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gCell
      jk_excite_cell uCell (
        .q (q_fb[gi]),
        .t (exciteT[gi]),
        .j (jNext[gi]),
        .k (kNext[gi])
      );
    end
  endgenerate

  // Request FSM: J/K are nonzero only for the single DRIVE cycle, status pulses last one cycle
  always_ff @(posedge Clock or negedge ClrN) begin
    if (!ClrN) begin
      state   <= IDLE;
      targetR <= '0;
      J       <= '0;
      K       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      retries <= '0;
    end else begin
      J    <= '0;
      K    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            targetR <= target;
            retries <= '0;
            J       <= jNext;
            K       <= kNext;
            busy    <= 1'b1;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          state <= VERIFY;
        end
        VERIFY: begin
          if (q_fb == targetR) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (retries < RETRY_LIMIT) begin
            retries <= retries + RW'(1);
            J       <= jNext;
            K       <= kNext;
            state   <= DRIVE;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
